// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry result buffer and retired-op counter.
// Optional macro ALU_EXT_OPS_EN enables xor (100), sltu (110) and sll (111).
module alu_exec_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int EW = XLEN + 2;
`ifdef ALU_EXT_OPS_EN
    localparam int SHW = $clog2(XLEN);
`endif

    // Entry layout: {illegal, zero, result}; zero is derived from the final result.
    function automatic logic [EW-1:0] alu_compute(
        input logic [2:0]      ctrl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        logic            ill;
        res = {XLEN{1'b0}};
        ill = 1'b0;
        case (ctrl)
            3'b000:  res = a + b;
            3'b001:  res = a - b;
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b101:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_EXT_OPS_EN
            3'b100:  res = a ^ b;
            3'b110:  res = {{(XLEN-1){1'b0}}, (a < b)};
            3'b111:  res = a << b[SHW-1:0];
`endif
            default: begin
                res = {XLEN{1'b0}};
                ill = 1'b1;
            end
        endcase
        return {ill, (res == {XLEN{1'b0}}), res};
    endfunction

    logic [1:0]       count_q, count_d;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             accept_s;
    logic             pop_s;
    logic [EW-1:0]    new_entry_s;

    assign in_ready    = (count_q != 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign out_result  = head_q[XLEN-1:0];
    assign out_zero    = head_q[XLEN];
    assign out_illegal = head_q[XLEN+1];
    assign retired_cnt = retired_q;

    assign accept_s    = in_valid && in_ready;
    assign pop_s       = out_valid && out_ready;
    assign new_entry_s = alu_compute(alu_ctrl, src_a, src_b);

    // Buffer is a two-slot shift register: head_q is always the entry presented on out_*.
    always_comb begin
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        retired_d = retired_q;
        if (pop_s) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
        case ({accept_s, pop_s})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_d = new_entry_s;
                end else begin
                    tail_d = new_entry_s;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
            end
            // Accept with pop only happens at count==1 (full blocks accept, empty blocks pop).
            2'b11: begin
                head_d = new_entry_s;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            head_q    <= {EW{1'b0}};
            tail_q    <= {EW{1'b0}};
            retired_q <= {CNT_W{1'b0}};
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (expectations follow ALU_EXT_OPS_EN).
module tb_alu_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;
    logic [15:0] retired_cnt;

    int vectors = 0;
    int errors  = 0;

    alu_exec_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 3'd0; src_a = 32'd0; src_b = 32'd0;
        step();
        rst_n = 1'b1;
    endtask

    // One accept with out_ready low; leaves in_valid low afterwards.
    task automatic accept_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_ctrl = c; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        vectors++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
        vectors++; if (out_zero !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got z=%0b i=%0b want 0 0", out_zero, out_illegal); end
        vectors++; if (retired_cnt !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired_cnt); end
    endtask

    task automatic test_add();
        alu_ctrl = 3'b000; src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", out_valid); end
        vectors++; if (out_result !== 32'd12 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin
            errors++; $display("FAIL add_result got %h z=%0b i=%0b want 0000000c 0 0", out_result, out_zero, out_illegal); end
        step();
        vectors++; if (retired_cnt !== 16'd1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL add_pop got cnt=%0d v=%0b want 1 0", retired_cnt, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_sub();
        accept_op(3'b001, 32'h1234, 32'h1234);
        vectors++; if (out_result !== 32'd0 || out_zero !== 1'b1) begin
            errors++; $display("FAIL sub_equal got %h z=%0b want 0 1", out_result, out_zero); end
        pop_one();
        accept_op(3'b001, 32'd0, 32'd1);
        vectors++; if (out_result !== 32'hFFFF_FFFF || out_zero !== 1'b0) begin
            errors++; $display("FAIL sub_wrap got %h z=%0b want ffffffff 0", out_result, out_zero); end
        pop_one();
        vectors++; if (retired_cnt !== 16'd3) begin errors++; $display("FAIL sub_retired got %0d want 3", retired_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        alu_ctrl = 3'b000; src_a = 32'd1; src_b = 32'd1;
        step();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %0b want 1", in_ready); end
        alu_ctrl = 3'b011; src_a = 32'hF0; src_b = 32'h0F;
        step();
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %0b want 0", in_ready); end
        alu_ctrl = 3'b010; src_a = 32'hFF; src_b = 32'h0F;
        step();
        vectors++; if (in_ready !== 1'b0 || out_result !== 32'd2) begin
            errors++; $display("FAIL bp_blocked got rdy=%0b res=%h want 0 00000002", in_ready, out_result); end
        out_ready = 1'b1;
        step();
        vectors++; if (in_ready !== 1'b1 || out_result !== 32'hFF) begin
            errors++; $display("FAIL bp_pop1 got rdy=%0b res=%h want 1 000000ff", in_ready, out_result); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'h0F) begin
            errors++; $display("FAIL bp_pop2 got v=%0b res=%h want 1 0000000f", out_valid, out_result); end
        step();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || retired_cnt !== 16'd3) begin
            errors++; $display("FAIL bp_end got v=%0b cnt=%0d want 0 3", out_valid, retired_cnt); end
    endtask

    task automatic test_compare_and_ext();
        logic [31:0] exp_r;
        logic        exp_i;
        accept_op(3'b101, 32'hFFFF_FFFF, 32'd1);
        vectors++; if (out_result !== 32'd1 || out_illegal !== 1'b0) begin
            errors++; $display("FAIL slt_neg got %h i=%0b want 00000001 0", out_result, out_illegal); end
        pop_one();
        accept_op(3'b101, 32'd1, 32'hFFFF_FFFF);
        vectors++; if (out_result !== 32'd0 || out_zero !== 1'b1) begin
            errors++; $display("FAIL slt_pos got %h z=%0b want 0 1", out_result, out_zero); end
        pop_one();
`ifdef ALU_EXT_OPS_EN
        exp_r = 32'd1; exp_i = 1'b0;
`else
        exp_r = 32'd0; exp_i = 1'b1;
`endif
        accept_op(3'b110, 32'd1, 32'd2);
        vectors++; if (out_result !== exp_r || out_illegal !== exp_i || out_zero !== (exp_r == 32'd0)) begin
            errors++; $display("FAIL code110 got %h i=%0b z=%0b want %h i=%0b", out_result, out_illegal, out_zero, exp_r, exp_i); end
        pop_one();
`ifdef ALU_EXT_OPS_EN
        exp_r = 32'd6; exp_i = 1'b0;
`else
        exp_r = 32'd0; exp_i = 1'b1;
`endif
        accept_op(3'b111, 32'd3, 32'd33);
        vectors++; if (out_result !== exp_r || out_illegal !== exp_i) begin
            errors++; $display("FAIL code111 got %h i=%0b want %h i=%0b", out_result, out_illegal, exp_r, exp_i); end
        pop_one();
    endtask

    task automatic test_reset_midop();
        accept_op(3'b000, 32'd10, 32'd20);
        accept_op(3'b000, 32'd30, 32'd40);
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midop_full got rdy=%0b v=%0b want 0 1", in_ready, out_valid); end
        do_reset();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || retired_cnt !== 16'd0) begin
            errors++; $display("FAIL midop_reset got v=%0b rdy=%0b cnt=%0d want 0 1 0", out_valid, in_ready, retired_cnt); end
        accept_op(3'b000, 32'd2, 32'd3);
        vectors++; if (out_result !== 32'd5) begin errors++; $display("FAIL midop_fresh got %h want 00000005", out_result); end
        pop_one();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; alu_ctrl = 3'b000; src_b = 32'd100;
        for (int i = 0; i < 10; i++) begin
            src_a = 32'(i);
            step();
            vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'(i + 100)) begin
                errors++; $display("FAIL stream_%0d got v=%0b rdy=%0b res=%0d want 1 1 %0d", i, out_valid, in_ready, out_result, i + 100); end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        vectors++; if (retired_cnt !== 16'd10 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_end got cnt=%0d v=%0b want 10 0", retired_cnt, out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_compare_and_ext();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
